reg_wb_arbiter: RTL and testbench

//  Write side of the CC 32x32 register file: merges ALU results and asynchronous qubit-measurement results

---
 rtl/reg_wb_arbiter_pkg.sv | 24 ++
 rtl/reg_wb_arbiter_if.sv | 41 ++++
 rtl/reg_wb_arbiter_wb_fifo.sv | 61 ++++++
 rtl/reg_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types for the register-file write-back path.
// Rev 1.0
`default_nettype none

package reg_wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEAS = 2'd2
  } wb_grant_e;

endpackage

`default_nettype wire

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus: ALU/measurement result inputs, scoreboard and register-file write port.
// Rev 1.0
`default_nettype none

interface reg_wb_arbiter_if
  import reg_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              meas_valid;
  logic              meas_ready;
  logic [ADDR_W-1:0] meas_addr;
  logic [DATA_W-1:0] meas_data;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic [NREGS-1:0]  busy;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              err_waw;

  modport master (
    output alu_valid, alu_addr, alu_data, meas_valid, meas_addr, meas_data, pend_set, pend_addr,
    input  alu_ready, meas_ready, busy, rf_wr_en, rf_wr_addr, rf_wr_data, fifo_count, err_waw
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, meas_valid, meas_addr, meas_data, pend_set, pend_addr,
    output alu_ready, meas_ready, busy, rf_wr_en, rf_wr_addr, rf_wr_data, fifo_count, err_waw
  );

endinterface

`default_nettype wire

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of write-back entries; push is refused when full even if a pop happens.
// Rev 1.0
`default_nettype none

module reg_wb_arbiter_wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  input  wire logic                            i_push,
  input  wire wb_entry_t                       i_din,
  input  wire logic                            i_pop,
  output wb_entry_t                            o_dout,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [$clog2(FIFO_DEPTH):0]          o_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and buffered measurement results onto the single register-file write port,
// with anti-starvation arbitration and a pending-measurement scoreboard.
`default_nettype none

module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  reg_wb_arbiter_if.slave bus
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t          w_din;
  wb_entry_t          w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_force;
  wb_grant_e          w_grant;
  logic [SC_W-1:0]    r_starve;
  logic [NREGS-1:0]   r_busy;
  logic               r_err_waw;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  assign w_din.addr = bus.meas_addr;
  assign w_din.data = bus.meas_data;

  reg_wb_arbiter_wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.meas_valid),
    .i_din   (w_din),
    .i_pop   (w_grant == GNT_MEAS),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (bus.fifo_count)
  );

  assign w_force = (r_starve == SC_W'(STARVE_LIMIT)) && !w_empty;

  always_comb begin
    w_grant = GNT_NONE;
    if (bus.alu_valid && !w_force) begin
      w_grant = GNT_ALU;
    end else if (!w_empty) begin
      w_grant = GNT_MEAS;
    end
  end

  // Counts consecutive losses of a waiting FIFO head; saturates so the force stays asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || (w_grant == GNT_MEAS)) begin
      r_starve <= '0;
    end else if (r_starve != SC_W'(STARVE_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // The set is written after the clear so a same-cycle set of the popped address wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_err_waw <= 1'b0;
    end else begin
      if (w_grant == GNT_MEAS) begin
        r_busy[w_head.addr] <= 1'b0;
      end
      if (bus.pend_set && (bus.pend_addr != '0)) begin
        r_busy[bus.pend_addr] <= 1'b1;
      end
      if ((w_grant == GNT_ALU) && r_busy[bus.alu_addr] && (bus.alu_addr != '0)) begin
        r_err_waw <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (w_grant)
        GNT_ALU: begin
          r_wr_en   <= (bus.alu_addr != '0);
          r_wr_addr <= bus.alu_addr;
          r_wr_data <= bus.alu_data;
        end
        GNT_MEAS: begin
          r_wr_en   <= (w_head.addr != '0);
          r_wr_addr <= w_head.addr;
          r_wr_data <= w_head.data;
        end
        default: begin
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_ready  = !w_force;
  assign bus.meas_ready = !w_full;
  assign bus.busy       = r_busy;
  assign bus.err_waw    = r_err_waw;
  assign bus.rf_wr_en   = r_wr_en;
  assign bus.rf_wr_addr = r_wr_addr;
  assign bus.rf_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// Randomized and directed bench for reg_wb_arbiter against a queue-based behavioural model.
`default_nettype none

module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  reg_wb_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: measurement queue, loss count of the waiting head, pending bits, expected write port.
  wb_entry_t          m_q[$];
  int                 m_losses;
  logic [NREGS-1:0]   m_busy;
  logic               m_err;
  logic               m_en;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_data;

  task automatic model_reset();
    m_q.delete();
    m_losses = 0;
    m_busy   = '0;
    m_err    = 1'b0;
    m_en     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic drive_idle();
    bus.alu_valid  = 1'b0; bus.alu_addr  = '0; bus.alu_data  = '0;
    bus.meas_valid = 1'b0; bus.meas_addr = '0; bus.meas_data = '0;
    bus.pend_set   = 1'b0; bus.pend_addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive at negedge, check outputs, advance the model across the posedge.
  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input bit ps, input logic [ADDR_W-1:0] pa,
                      output bit acc_a, output bit acc_m, output bit obs_ar);
    bit        force_m, meas_g, was_empty;
    wb_entry_t e;
    bus.alu_valid  = av; bus.alu_addr  = aa; bus.alu_data  = ad;
    bus.meas_valid = mv; bus.meas_addr = ma; bus.meas_data = md;
    bus.pend_set   = ps; bus.pend_addr = pa;
    #1;
    force_m = (m_losses == LIMIT) && (m_q.size() > 0);
    obs_ar  = bus.alu_ready;
    check("alu_ready",  64'(bus.alu_ready),  64'(!force_m));
    check("meas_ready", 64'(bus.meas_ready), 64'(m_q.size() < DEPTH));
    check("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
    check("busy",       64'(bus.busy),       64'(m_busy));
    check("err_waw",    64'(bus.err_waw),    64'(m_err));
    check("rf_wr_en",   64'(bus.rf_wr_en),   64'(m_en));
    check("rf_wr_addr", 64'(bus.rf_wr_addr), 64'(m_addr));
    check("rf_wr_data", 64'(bus.rf_wr_data), 64'(m_data));

    acc_a     = av && !force_m;
    meas_g    = !acc_a && (m_q.size() > 0);
    acc_m     = mv && (m_q.size() < DEPTH);
    was_empty = (m_q.size() == 0);
    if (acc_a) begin
      if (m_busy[aa] && aa != 0) m_err = 1'b1;
      m_en = (aa != 0); m_addr = aa; m_data = ad;
    end else if (meas_g) begin
      e = m_q.pop_front();
      m_busy[e.addr] = 1'b0;
      m_en = (e.addr != 0); m_addr = e.addr; m_data = e.data;
    end else begin
      m_en = 1'b0;
    end
    if (meas_g || was_empty) m_losses = 0;
    else if (m_losses < LIMIT) m_losses++;
    if (acc_m) begin
      e.addr = ma; e.data = md;
      m_q.push_back(e);
    end
    if (ps && pa != 0) m_busy[pa] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a, m, r;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a, m, r);
  endtask

  initial begin
    bit a, m, r, hold_a, hold_m, av, mv, ps;
    logic [ADDR_W-1:0] aa, ma, pa;
    logic [DATA_W-1:0] ad, md;
    int low_cnt, alu_pct, meas_pct, tries;

    drive_idle();
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_en",    64'(bus.rf_wr_en),   64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_aready", 64'(bus.alu_ready), 64'd1);
    check("rst_mready", 64'(bus.meas_ready), 64'd1);

    // ALU only
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, a, m, r);
    check("t1_en",   64'(bus.rf_wr_en),   64'd1);
    check("t1_addr", 64'(bus.rf_wr_addr), 64'd5);
    check("t1_data", 64'(bus.rf_wr_data), 64'hDEAD_BEEF);

    // Collision: ALU first, FIFO head next cycle
    step(0, 0, 0, 1, 7, 32'h1, 0, 0, a, m, r);
    step(1, 3, 32'h11, 0, 0, 0, 0, 0, a, m, r);
    check("t2_alu_addr", 64'(bus.rf_wr_addr), 64'd3);
    check("t2_count1",   64'(bus.fifo_count), 64'd1);
    idle(1);
    check("t2_meas_addr", 64'(bus.rf_wr_addr), 64'd7);
    check("t2_count0",    64'(bus.fifo_count), 64'd0);

    // Starvation
    step(0, 0, 0, 1, 9, 32'h1, 0, 0, a, m, r);
    low_cnt = 0; hold_a = 0; ad = 32'h100;
    for (int k = 0; k < 12; k++) begin
      if (!hold_a) ad = ad + 1;
      step(1, 10, ad, 0, 0, 0, 0, 0, a, m, r);
      if (!r) low_cnt++;
      hold_a = !a;
    end
    check("t3_ready_low", 64'(low_cnt), 64'd1);
    idle(2);

    // FIFO full
    for (int k = 0; k < 4; k++) step(1, 11, 32'(k), 1, 20, 32'(k), 0, 0, a, m, r);
    check("t4_count", 64'(bus.fifo_count), 64'd4);
    check("t4_ready", 64'(bus.meas_ready), 64'd0);
    tries = 0; m = 0;
    while (!m && tries < 20) begin
      step(1, 11, 32'h50 + 32'(tries), 1, 21, 32'h5, 0, 0, a, m, r);
      tries++;
    end
    check("t4_fifth_accepted", 64'(m), 64'd1);
    idle(6);

    // Scoreboard
    step(0, 0, 0, 0, 0, 0, 1, 12, a, m, r);
    check("t5_busy_set", 64'(bus.busy[12]), 64'd1);
    step(1, 12, 32'h77, 0, 0, 0, 0, 0, a, m, r);
    check("t5_err", 64'(bus.err_waw), 64'd1);
    step(0, 0, 0, 1, 12, 32'h1, 0, 0, a, m, r);
    idle(1);
    check("t5_busy_clr", 64'(bus.busy[12]), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, 12, a, m, r);
    step(0, 0, 0, 1, 12, 32'h2, 0, 0, a, m, r);
    step(0, 0, 0, 0, 0, 0, 1, 12, a, m, r);
    check("t5_set_wins", 64'(bus.busy[12]), 64'd1);

    // r0 and reset with queued entries
    step(0, 0, 0, 1, 0, 32'hFF, 0, 0, a, m, r);
    idle(1);
    check("t6_r0_no_wr", 64'(bus.rf_wr_en), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, 4, a, m, r);
    for (int k = 0; k < 3; k++) step(1, 2, 32'(k), 1, 13, 32'(k), 0, 0, a, m, r);
    check("t6_queued", 64'(bus.fifo_count), 64'd3);
    do_reset();
    check("t6_rst_count", 64'(bus.fifo_count), 64'd0);
    check("t6_rst_busy",  64'(bus.busy),       64'd0);
    check("t6_rst_err",   64'(bus.err_waw),    64'd0);
    idle(1);
    check("t6_rst_no_wr", 64'(bus.rf_wr_en), 64'd0);

    // Randomized traffic
    hold_a = 0; hold_m = 0;
    av = 0; aa = 0; ad = 0; mv = 0; ma = 0; md = 0;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       begin alu_pct = 90; meas_pct = 60; end
        1:       begin alu_pct = 50; meas_pct = 40; end
        default: begin alu_pct = 20; meas_pct = 30; end
      endcase
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        hold_a = 0; hold_m = 0;
        continue;
      end
      if (!hold_a) begin
        av = ($urandom_range(0, 99) < alu_pct);
        aa = ADDR_W'($urandom_range(0, 15));
        ad = $urandom;
      end
      if (!hold_m) begin
        mv = ($urandom_range(0, 99) < meas_pct);
        ma = ADDR_W'($urandom_range(0, 15));
        md = $urandom;
      end
      ps = ($urandom_range(0, 3) == 0);
      pa = ADDR_W'($urandom_range(0, 15));
      step(av, aa, ad, mv, ma, md, ps, pa, a, m, r);
      hold_a = av && !a;
      hold_m = mv && !m;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
